// File: rtl/vc_plane_sched_if.sv
// +----------------------------------------------------------------------------+
// | vc_plane_sched_if : plane request/type inputs and selector outputs of the   |
// | VC plane scheduler. Optional macro: VC_SCHED_PKT_COUNT_EN (pkt_count).      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface vc_plane_sched_if #(
    parameter int VC         = 4,
    parameter int TYPE_WIDTH = 2
);
    logic [VC:0]                  plane_req;
    logic [(VC+1)*TYPE_WIDTH-1:0] flit_type;
    logic                         handshake;
    logic [VC:0]                  VCPlaneSelector;
    logic                         grant_active;
    logic                         pkt_error;
`ifdef VC_SCHED_PKT_COUNT_EN
    logic [15:0]                  pkt_count;

    modport master (
        output plane_req, flit_type, handshake,
        input  VCPlaneSelector, grant_active, pkt_error, pkt_count
    );
    modport slave (
        input  plane_req, flit_type, handshake,
        output VCPlaneSelector, grant_active, pkt_error, pkt_count
    );
`else
    modport master (
        output plane_req, flit_type, handshake,
        input  VCPlaneSelector, grant_active, pkt_error
    );
    modport slave (
        input  plane_req, flit_type, handshake,
        output VCPlaneSelector, grant_active, pkt_error
    );
`endif
endinterface

`default_nettype wire

// File: rtl/vc_plane_scheduler.sv
// +----------------------------------------------------------------------------+
// | vc_plane_scheduler : round-robin wormhole scheduler sharing one link among  |
// | VC+1 planes. Optional macro: VC_SCHED_PKT_COUNT_EN adds pkt_count.          |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module vc_plane_scheduler #(
    parameter int VC              = 4,
    parameter int TYPE_WIDTH      = 2,
    parameter int FLIT_PER_PACKET = 6
) (
    input  logic             clk,
    input  logic             rst,
    vc_plane_sched_if.slave  bus
);
    localparam int c_PTR_W = (VC > 0) ? $clog2(VC + 1) : 1;
    localparam int c_CNT_W = $clog2(FLIT_PER_PACKET + 1);
    localparam logic [c_PTR_W-1:0]    c_LAST_PTR  = c_PTR_W'(VC);
    localparam logic [c_CNT_W-1:0]    c_BEAT_LAST = c_CNT_W'(FLIT_PER_PACKET - 1);
    localparam logic [TYPE_WIDTH-1:0] c_HEAD      = TYPE_WIDTH'(2'b01);
    localparam logic [TYPE_WIDTH-1:0] c_TAIL      = TYPE_WIDTH'(2'b11);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t               r_state;
    logic [VC:0]          r_sel;
    logic                 r_active;
    logic                 r_err;
    logic [c_PTR_W-1:0]   r_rr_ptr;
    logic [c_PTR_W-1:0]   r_grant_idx;
    logic [c_CNT_W-1:0]   r_beat_cnt;

    logic [TYPE_WIDTH-1:0] w_type [VC:0];
    logic [VC:0]           w_elig;
    logic [VC:0]           w_cand;
    logic [VC:0]           w_win_onehot;
    logic [TYPE_WIDTH-1:0] w_cur_type;
    logic                  w_beat;
    logic                  w_tail_rel;
    logic                  w_force_rel;
    logic                  w_release;
    logic [c_PTR_W-1:0]    w_next_ptr;
    logic [c_PTR_W-1:0]    w_start;
    logic [c_PTR_W:0]      w_scan;
    logic                  w_found;
    logic [c_PTR_W-1:0]    w_win;

    generate
        for (genvar i = 0; i <= VC; i++) begin : g_plane
            assign w_type[i] = bus.flit_type[i*TYPE_WIDTH +: TYPE_WIDTH];
            assign w_elig[i] = bus.plane_req[i] && (w_type[i] == c_HEAD);
        end
    endgenerate

    assign w_cur_type  = w_type[r_grant_idx];
    assign w_beat      = (r_state == S_LOCKED) && bus.handshake;
    assign w_tail_rel  = w_beat && (w_cur_type == c_TAIL);
    assign w_force_rel = w_beat && (w_cur_type != c_TAIL) && (r_beat_cnt == c_BEAT_LAST);
    assign w_release   = w_tail_rel || w_force_rel;
    assign w_next_ptr  = (r_grant_idx == c_LAST_PTR) ? '0 : r_grant_idx + c_PTR_W'(1);

    // A releasing plane is masked and the search restarts just past it,
    // so the next grant can be issued in the same cycle as the release.
    assign w_start = w_release ? w_next_ptr : r_rr_ptr;
    assign w_cand  = w_elig & ~({(VC+1){w_release}} & r_sel);

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_scan  = '0;
        for (int k = 0; k <= VC; k++) begin
            w_scan = {1'b0, w_start} + (c_PTR_W+1)'(k);
            if (w_scan > {1'b0, c_LAST_PTR}) begin
                w_scan = w_scan - (c_PTR_W+1)'(VC + 1);
            end
            if (!w_found && w_cand[w_scan[c_PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_scan[c_PTR_W-1:0];
            end
        end
    end

    assign w_win_onehot = (VC+1)'(1) << w_win;

`ifdef VC_SCHED_PKT_COUNT_EN
    logic [15:0] r_pkt_count;
    assign bus.pkt_count = r_pkt_count;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sel       <= '0;
            r_active    <= 1'b0;
            r_err       <= 1'b0;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_beat_cnt  <= '0;
`ifdef VC_SCHED_PKT_COUNT_EN
            r_pkt_count <= '0;
`endif
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_sel       <= w_win_onehot;
                        r_grant_idx <= w_win;
                        r_active    <= 1'b1;
                        r_beat_cnt  <= '0;
                        r_state     <= S_LOCKED;
                    end
                end
                S_LOCKED: begin
                    if (w_release) begin
                        r_rr_ptr   <= w_next_ptr;
                        r_err      <= w_force_rel;
                        r_beat_cnt <= '0;
`ifdef VC_SCHED_PKT_COUNT_EN
                        if (r_pkt_count != 16'hFFFF) begin
                            r_pkt_count <= r_pkt_count + 16'd1;
                        end
`endif
                        if (w_found) begin
                            r_sel       <= w_win_onehot;
                            r_grant_idx <= w_win;
                        end else begin
                            r_sel    <= '0;
                            r_active <= 1'b0;
                            r_state  <= S_IDLE;
                        end
                    end else if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + c_CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.VCPlaneSelector = r_sel;
    assign bus.grant_active    = r_active;
    assign bus.pkt_error       = r_err;

endmodule

`default_nettype wire
